// File: rtl/activation_pkg.sv
// activation_pkg: shared types, PWL sigmoid constants and transfer/derivative helpers
package activation_pkg;
    typedef enum logic {KIND_SIGMOID = 1'b0, KIND_RELU = 1'b1} kind_e;
    typedef logic signed [15:0] arg_t;
    typedef logic [7:0] res_t;
    typedef logic signed [15:0] err_t;
    typedef logic signed [15:0] fbk_t;
    typedef logic [8:0] deriv_t;
    localparam logic [15:0] BP0 = 16'd256;
    localparam logic [15:0] BP1 = 16'd608;
    localparam logic [15:0] BP2 = 16'd1280;
    localparam logic [8:0] OFS0 = 9'd128;
    localparam logic [8:0] OFS1 = 9'd160;
    localparam logic [8:0] OFS2 = 9'd216;
    function automatic res_t act_res(kind_e kind, arg_t x);
        logic [15:0] a;
        logic [8:0] p, y;
        // -32768 negates to 0x8000, which as unsigned already lands in the saturated segment
        a = x[15] ? 16'(-x) : 16'(x);
        p = a < BP0 ? OFS0 + 9'(a >> 2) :
            a < BP1 ? OFS1 + 9'(a >> 3) :
            a < BP2 ? OFS2 + 9'(a >> 5) : 9'd256;
        y = x[15] ? 9'd256 - p : p;
        if (kind == KIND_RELU)
            return (x[15] || x == '0) ? 8'h00 : (|x[14:8]) ? 8'hFF : x[7:0];
        return y[8] ? 8'hFF : y[7:0];
    endfunction
    function automatic deriv_t act_deriv(kind_e kind, arg_t x, res_t y);
        logic [16:0] prod;
        prod = 17'(y) * 17'(9'd256 - 9'(y));
        if (kind == KIND_RELU)
            return (!x[15] && x != '0) ? 9'd256 : 9'd0;
        return 9'(prod >> 8);
    endfunction
    function automatic fbk_t scale(err_t e, deriv_t d);
        logic signed [25:0] prod;
        prod = 26'(e) * 26'($signed({1'b0, d}));
        return prod[23:8];
    endfunction
endpackage

// File: rtl/activation_stash.sv
// activation_stash: FIFO of derivatives awaiting backprop; pointers wrap modulo DEPTH
module activation_stash #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        wptr_d = wptr_q + AW'(push_i);
        rptr_d = rptr_q + AW'(pop_i);
        cnt_d  = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wptr_q] <= wdata_i;
    end
    assign rdata_o = mem_q[rptr_q];
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/activation.sv
// activation: registered sigmoid/ReLU forward path; with ACTIVATION_TRAIN_EN defined,
// derivatives are stashed and scale the backward error into registered feedback.
module activation
    import activation_pkg::*;
#(
    parameter int KIND  = 0,
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic train,
    input  logic arg_valid,
    output logic arg_ready,
    input  arg_t arg_data,
    output logic res_valid,
    input  logic res_ready,
    output res_t res_data,
    input  logic err_valid,
    output logic err_ready,
    input  err_t err_data,
    output logic fbk_valid,
    input  logic fbk_ready,
    output fbk_t fbk_data
);
    localparam kind_e K = kind_e'(KIND[0]);
    logic res_valid_q, res_valid_d, fwd_free, arg_fire;
    res_t res_data_q, res_data_d, y;
    assign y        = act_res(K, arg_data);
    assign fwd_free = !res_valid_q || res_ready;
    assign arg_fire = arg_valid && arg_ready;
    always_comb begin
        res_valid_d = arg_fire || (res_valid_q && !res_ready);
        res_data_d  = arg_fire ? y : res_data_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
`ifdef ACTIVATION_TRAIN_EN
    logic full, empty, err_fire, fbk_valid_q, fbk_valid_d;
    deriv_t d, d_pop;
    fbk_t fbk_data_q, fbk_data_d;
    assign d         = act_deriv(K, arg_data, y);
    // full gates only training args; a same-cycle pop frees the slot from the next cycle
    assign arg_ready = reset && fwd_free && !(train && full);
    assign err_ready = reset && !empty && (!fbk_valid_q || fbk_ready);
    assign err_fire  = err_valid && err_ready;
    activation_stash #(.WIDTH(9), .DEPTH(DEPTH)) u_stash (
        .clock   (clock),
        .reset   (reset),
        .push_i  (arg_fire && train),
        .pop_i   (err_fire),
        .wdata_i (d),
        .rdata_o (d_pop),
        .full_o  (full),
        .empty_o (empty)
    );
    always_comb begin
        fbk_valid_d = err_fire || (fbk_valid_q && !fbk_ready);
        fbk_data_d  = err_fire ? scale(err_data, d_pop) : fbk_data_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            fbk_valid_q <= 1'b0;
            fbk_data_q  <= '0;
        end else begin
            fbk_valid_q <= fbk_valid_d;
            fbk_data_q  <= fbk_data_d;
        end
    end
    assign fbk_valid = fbk_valid_q;
    assign fbk_data  = fbk_data_q;
`else
    logic unused;
    assign unused    = ^{train, err_valid, err_data, fbk_ready};
    assign arg_ready = reset && fwd_free;
    assign err_ready = 1'b0;
    assign fbk_valid = 1'b0;
    assign fbk_data  = '0;
`endif
endmodule

// File: tb/tb_activation.sv
// tb_activation: randomized + directed bench for both activation kinds against a behavioural model
module tb_activation;
    localparam int DEPTH = 4;
`ifdef ACTIVATION_TRAIN_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif
    logic clock = 1'b0;
    logic reset, train, arg_valid, res_ready, err_valid, fbk_ready;
    logic [15:0] arg_data, err_data;
    logic [1:0] arg_ready, err_ready, res_valid, fbk_valid;
    logic [7:0] res_data [2];
    logic [15:0] fbk_data [2];
    int total = 0, bad = 0;
    bit chk_on = 1'b0;
    bit exp_rv = 1'b0, exp_fv = 1'b0, last_afire = 1'b0, last_efire = 1'b0;
    int exp_rd [2] = '{0, 0};
    int exp_fd [2] = '{0, 0};
    int q0 [$];
    int q1 [$];

    always #5 clock = ~clock;

    activation #(.KIND(0), .DEPTH(DEPTH)) u0 (
        .clock(clock), .reset(reset), .train(train),
        .arg_valid(arg_valid), .arg_ready(arg_ready[0]), .arg_data(arg_data),
        .res_valid(res_valid[0]), .res_ready(res_ready), .res_data(res_data[0]),
        .err_valid(err_valid), .err_ready(err_ready[0]), .err_data(err_data),
        .fbk_valid(fbk_valid[0]), .fbk_ready(fbk_ready), .fbk_data(fbk_data[0]));
    activation #(.KIND(1), .DEPTH(DEPTH)) u1 (
        .clock(clock), .reset(reset), .train(train),
        .arg_valid(arg_valid), .arg_ready(arg_ready[1]), .arg_data(arg_data),
        .res_valid(res_valid[1]), .res_ready(res_ready), .res_data(res_data[1]),
        .err_valid(err_valid), .err_ready(err_ready[1]), .err_data(err_data),
        .fbk_valid(fbk_valid[1]), .fbk_ready(fbk_ready), .fbk_data(fbk_data[1]));

    function automatic int sig_ref(int x);
        int a, p, y;
        a = x < 0 ? -x : x;
        if (a < 256) p = 128 + a / 4;
        else if (a < 608) p = 160 + a / 8;
        else if (a < 1280) p = 216 + a / 32;
        else p = 256;
        y = x >= 0 ? p : 256 - p;
        return y > 255 ? 255 : y;
    endfunction
    function automatic int relu_ref(int x);
        return x <= 0 ? 0 : x >= 256 ? 255 : x;
    endfunction
    function automatic int deriv_ref(int k, int x);
        int y;
        y = k == 0 ? sig_ref(x) : relu_ref(x);
        return k == 0 ? (y * (256 - y)) / 256 : (x > 0 ? 256 : 0);
    endfunction
    function automatic int fbk_ref(int e, int d);
        int p;
        p = e * d;
        return (p >>> 8) & 32'hFFFF;
    endfunction
    function automatic bit exp_ar();
        return reset && (!exp_rv || res_ready) && !(TR && train && q0.size() == DEPTH);
    endfunction
    function automatic bit exp_er();
        return TR && reset && q0.size() > 0 && (!exp_fv || fbk_ready);
    endfunction
    function automatic logic [15:0] rnd();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'($urandom_range(0, 3000) - 1500);
            3: return 16'($urandom);
            4: return 16'h0000;
            default: return 16'($urandom_range(0, 600) - 300);
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", n, got, want, $time);
        end
    endtask

    // reference model: advances on each rising edge from the sampled inputs
    always @(posedge clock) begin
        int x, e;
        bit af, ef;
        if (!reset) begin
            exp_rv = 1'b0; exp_fv = 1'b0; exp_rd = '{0, 0}; exp_fd = '{0, 0};
            q0.delete(); q1.delete(); last_afire = 1'b0; last_efire = 1'b0;
        end else begin
            af = arg_valid && exp_ar();
            ef = err_valid && exp_er();
            x = int'($signed(arg_data));
            e = int'($signed(err_data));
            if (ef) begin
                exp_fd[0] = fbk_ref(e, q0.pop_front());
                exp_fd[1] = fbk_ref(e, q1.pop_front());
            end
            exp_fv = ef || (exp_fv && !fbk_ready);
            if (af) begin
                exp_rd[0] = sig_ref(x);
                exp_rd[1] = relu_ref(x);
                if (TR && train) begin
                    q0.push_back(deriv_ref(0, x));
                    q1.push_back(deriv_ref(1, x));
                end
            end
            exp_rv = af || (exp_rv && !res_ready);
            last_afire = af;
            last_efire = ef;
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("arg_ready%0d", k), 32'(arg_ready[k]), 32'(exp_ar()));
                chk($sformatf("err_ready%0d", k), 32'(err_ready[k]), 32'(exp_er()));
                chk($sformatf("res_valid%0d", k), 32'(res_valid[k]), 32'(exp_rv));
                chk($sformatf("res_data%0d", k), 32'(res_data[k]), 32'(exp_rd[k]));
                chk($sformatf("fbk_valid%0d", k), 32'(fbk_valid[k]), 32'(exp_fv));
                chk($sformatf("fbk_data%0d", k), 32'(fbk_data[k]), 32'(exp_fd[k]));
            end
        end
    end

    task automatic send_arg(input logic [15:0] x, input logic tr);
        int n;
        n = 0;
        arg_valid = 1'b1; arg_data = x; train = tr;
        @(negedge clock);
        while (!arg_ready[0] && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) begin total++; bad++; $display("FAIL arg_timeout got=stalled want=accept"); end
        @(posedge clock); #1;
        arg_valid = 1'b0;
    endtask
    task automatic send_err(input logic [15:0] e);
        int n;
        n = 0;
        err_valid = 1'b1; err_data = e;
        @(negedge clock);
        while (!err_ready[0] && n < 100) begin @(negedge clock); n++; end
        if (n >= 100) begin total++; bad++; $display("FAIL err_timeout got=stalled want=accept"); end
        @(posedge clock); #1;
        err_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] held;
        reset = 1'b0; train = 1'b0; arg_valid = 1'b0; res_ready = 1'b1;
        err_valid = 1'b0; fbk_ready = 1'b1; arg_data = '0; err_data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_arg_ready", 32'(arg_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk_on = 1'b1;
        reset = 1'b1;
        chk("pin_sig_neg", 32'(sig_ref(-256)), 32'd64);
        chk("pin_sig_min", 32'(sig_ref(-32768)), 32'd0);
        chk("pin_fbk_neg", 32'(fbk_ref(-256, 48)), 32'h0000FFD0);
        chk("pin_deriv", 32'(deriv_ref(0, 256)), 32'd48);
        send_arg(16'h0000, 1'b1);
        chk("sig_zero", 32'(res_data[0]), 32'h80);
        chk("relu_zero", 32'(res_data[1]), 32'h00);
`ifdef ACTIVATION_TRAIN_EN
        send_err(16'h0200);
        chk("fbk_zero0", 32'(fbk_data[0]), 32'h0080);
        chk("fbk_zero1", 32'(fbk_data[1]), 32'h0000);
`endif
        send_arg(16'h0600, 1'b1);
        chk("sig_sat", 32'(res_data[0]), 32'hFF);
        chk("relu_sat", 32'(res_data[1]), 32'hFF);
`ifdef ACTIVATION_TRAIN_EN
        send_err(16'hFE00);
        chk("fbk_sat0", 32'(fbk_data[0]), 32'h0000);
        chk("fbk_sat1", 32'(fbk_data[1]), 32'hFE00);
`endif
        send_arg(16'hFA00, 1'b0);
        chk("sig_negsat", 32'(res_data[0]), 32'h00);
        send_arg(16'h0100, 1'b1);
        chk("sig_p1", 32'(res_data[0]), 32'hC0);
        chk("relu_p1", 32'(res_data[1]), 32'hFF);
        send_arg(16'hFF00, 1'b1);
        chk("sig_m1", 32'(res_data[0]), 32'h40);
        chk("relu_m1", 32'(res_data[1]), 32'h00);
`ifdef ACTIVATION_TRAIN_EN
        send_err(16'h0100);
        chk("fifo_a0", 32'(fbk_data[0]), 32'h0030);
        chk("fifo_a1", 32'(fbk_data[1]), 32'h0100);
        send_err(16'hFF00);
        chk("fifo_b0", 32'(fbk_data[0]), 32'hFFD0);
        chk("fifo_b1", 32'(fbk_data[1]), 32'h0000);
`endif
        send_arg(16'h0080, 1'b1);
        chk("relu_half", 32'(res_data[1]), 32'h80);
        chk("sig_half", 32'(res_data[0]), 32'hA0);
        send_arg(16'hFF80, 1'b1);
        chk("relu_mhalf", 32'(res_data[1]), 32'h00);
        send_arg(16'h0300, 1'b1);
        chk("relu_three", 32'(res_data[1]), 32'hFF);
        chk("sig_three", 32'(res_data[0]), 32'hF0);
`ifdef ACTIVATION_TRAIN_EN
        send_err(16'h1234);
        chk("relu_e1", 32'(fbk_data[1]), 32'h1234);
        chk("sig_e1", 32'(fbk_data[0]), 32'h0444);
        send_err(16'h1234);
        chk("relu_e2", 32'(fbk_data[1]), 32'h0000);
        send_err(16'h1234);
        chk("relu_e3", 32'(fbk_data[1]), 32'h1234);
        chk("sig_e3", 32'(fbk_data[0]), 32'h0111);
        // fill the stash, stall the fifth training arg, release it with one pop
        for (int i = 0; i < DEPTH; i++) send_arg(16'(i * 100), 1'b1);
        arg_valid = 1'b1; arg_data = 16'h0123; train = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("stall_ready", 32'(arg_ready[0]), 32'd0);
        end
        @(posedge clock); #1;
        err_valid = 1'b1; err_data = 16'h0100;
        @(negedge clock);
        chk("pop_full_ready", 32'(arg_ready[0]), 32'd0);
        chk("pop_err_ready", 32'(err_ready[0]), 32'd1);
        @(posedge clock); #1;
        err_valid = 1'b0;
        @(negedge clock);
        chk("freed_ready", 32'(arg_ready[0]), 32'd1);
        @(posedge clock); #1;
        arg_valid = 1'b0;
        res_ready = 1'b0;
        held = res_data[0];
        chk("fifth_valid", 32'(res_valid[0]), 32'd1);
        repeat (3) begin
            @(posedge clock); #1;
            chk("hold_valid", 32'(res_valid[0]), 32'd1);
            chk("hold_data", 32'(res_data[0]), 32'(held));
        end
        res_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) send_err(16'($urandom));
`endif
        // reset with stashed entries and a pending result
        send_arg(16'h0100, 1'b1);
        send_arg(16'h0200, 1'b1);
        res_ready = 1'b0;
        chk("pre_rst_valid", 32'(res_valid[0]), 32'd1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        res_ready = 1'b1;
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        chk("post_rst_data", 32'(res_data[0]), 32'd0);
        repeat (3) begin
            @(posedge clock); #1;
            chk("post_rst_err_ready", 32'(err_ready), 32'd0);
        end
        send_arg(16'h0000, 1'b1);
`ifdef ACTIVATION_TRAIN_EN
        chk("new_err_ready", 32'(err_ready[0]), 32'd1);
        send_err(16'h0100);
        chk("new_fbk", 32'(fbk_data[0]), 32'h0040);
`else
        chk("notrain_err_ready", 32'(err_ready), 32'd0);
        chk("notrain_fbk_valid", 32'(fbk_valid), 32'd0);
`endif
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            if (!arg_valid || last_afire) begin
                arg_valid = $urandom_range(0, 2) != 0;
                arg_data = rnd();
                train = $urandom_range(0, 3) != 0;
            end
            if (!err_valid || last_efire) begin
                err_valid = $urandom_range(0, 2) == 0;
                err_data = rnd();
            end
            res_ready = $urandom_range(0, 3) != 0;
            fbk_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 299) != 0;
            if (!reset) begin
                arg_valid = 1'b0;
                err_valid = 1'b0;
            end
        end
        @(posedge clock); #1;
        arg_valid = 1'b0; err_valid = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/activation.md
ACTIVATION -- requirements
Module: activation

Interface
REQ-001 Parameter KIND, default 0, activation select: 0 sigmoid, 1 ReLU.
REQ-002 Parameter DEPTH, default 4, stash entries for derivatives awaiting backprop; power of two, 2..64.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 train  input  1  sampled at arg acceptance; 1 = push derivative to stash.
REQ-006 arg_valid/arg_ready/arg_data  in/out/in  1/1/16  forward argument, signed Q8.8.
REQ-007 res_valid/res_ready/res_data  out/in/out  1/1/8  forward result, unsigned Q0.8.
REQ-008 err_valid/err_ready/err_data  in/out/in  1/1/16  backward error, signed Q8.8.
REQ-009 fbk_valid/fbk_ready/fbk_data  out/in/out  1/1/16  backward feedback, signed Q8.8.

Function
REQ-010 Transfer on any channel SHALL occur only on a rising edge with valid && ready; valid, once high, SHALL hold with stable data until transfer.
REQ-011 arg_ready SHALL be (!res_valid || res_ready) && !(train && stash full); combinational, no dependence on arg_valid.
REQ-012 Forward latency SHALL be 1 cycle: res_valid rises the edge after acceptance; back-to-back accepts at full rate with res_ready held 1.
REQ-013 Sigmoid (KIND 0), a=|x| in Q8.8 LSBs: a<256: p=128+(a>>2); a<608: p=160+(a>>3); a<1280: p=216+(a>>5); else p=256.
REQ-014 Sigmoid y SHALL be p for x>=0, 256-p for x<0, then saturated to 255; x=-32768 treated as a>=1280.
REQ-015 ReLU (KIND 1): x<=0 -> 0; x>=256 -> 255; else x[7:0].
REQ-016 Derivative d, 9-bit unsigned Q0.8: sigmoid d=(y*(256-y))>>8; ReLU d=256 if x>0 else 0.
REQ-017 On arg acceptance with train=1, d SHALL be pushed to the stash; with train=0, stash unchanged.
REQ-018 err_ready SHALL be stash non-empty && (!fbk_valid || fbk_ready); empty stash blocks err.
REQ-019 On err acceptance, oldest d SHALL pop (FIFO order); fbk_data = (err_data*d)>>>8 (arithmetic, floor), registered, fbk_valid rises next edge.
REQ-020 Simultaneous push and pop in one cycle SHALL both occur; count unchanged; pop of a full stash in that cycle frees arg_ready only from the next cycle.
REQ-021 Stash pointers SHALL wrap modulo DEPTH; occupancy count DEPTH+1 states, no overflow/underflow possible.

Reset
REQ-022 reset=0 at an edge SHALL clear res_valid, fbk_valid, res_data, fbk_data, stash pointers and count; in-flight transfers discarded.
REQ-023 While reset=0, arg_ready and err_ready SHALL be 0.

Configuration
REQ-024 Macro ACTIVATION_TRAIN_EN defined: stash, err and fbk paths as above.
REQ-025 ACTIVATION_TRAIN_EN undefined: no stash; train ignored; err_ready=0, fbk_valid=0, fbk_data=0 constantly; forward unchanged.

Structure
REQ-026 Package activation_pkg SHALL hold kind enum, arg_t/res_t/err_t/fbk_t/deriv_t typedefs, PWL breakpoints (256, 608, 1280) and offsets (128, 160, 216).
REQ-027 Stash SHALL be sub-module activation_stash (parametrised FIFO, WIDTH=9, DEPTH), instantiated only under ACTIVATION_TRAIN_EN.

Verification
REQ-028 KIND 0, arg 0x0000 -> res 0x80; train=1, err 0x0200 -> fbk 0x0080.
REQ-029 KIND 0, train=1, arg 0x0600 -> res 0xFF; err 0xFE00 -> fbk 0x0000; arg 0xFA00 -> res 0x00.
REQ-030 KIND 0, train=1, args 0x0100 then 0xFF00 -> res 0xC0, 0x40; errs 0x0100, 0xFF00 -> fbk 0x0030, 0xFFD0 (FIFO order).
REQ-031 KIND 1, train=1, args 0x0080, 0xFF80, 0x0300 -> res 0x80, 0x00, 0xFF; errs 0x1234 x3 -> fbk 0x1234, 0x0000, 0x1234.
REQ-032 DEPTH 4, train=1, 5 args, no err -> 5th stalls (arg_ready=0); one err accepted -> 5th accepted next cycle; res_ready=0 for 3 cycles holds res stable.
REQ-033 reset=0 with 2 stashed entries and res_valid=1 -> res_valid=0, err_ready=0 after reset release until new train arg.
